// File: rtl/weight_fetch_ctrl.sv
// rtl/weight_fetch_ctrl.sv - weight fetch read master
// Splits one fetch command into power-of-two read bursts and streams the beats into the weight buffer.
module weight_fetch_ctrl #(
   parameter int DW            = 32,
   parameter int AW            = 32,
   parameter int BAW           = 10,
   parameter int LW            = 14,
   parameter int MAX_BURST_LOG = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [AW-1:0]  req_addr,
   input  logic [LW-1:0]  req_len,
   input  logic [BAW-1:0] req_buf_base,
   output logic           busy,
   output logic           done,
   output logic [AW-1:0]  araddr,
   output logic           arvalid,
   output logic [3:0]     arburst,
   input  logic           arready,
   input  logic [DW-1:0]  rdata,
   input  logic           rvalid,
   input  logic           rlast,
   output logic           wb_wen,
   output logic [BAW-1:0] wb_waddr,
   output logic [DW-1:0]  wb_wdata
);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

   state_t         state_q, state_d;
   logic [AW-1:0]  araddr_q, araddr_d;
   logic [3:0]     arburst_q, arburst_d;
   logic [LW-1:0]  rem_q, rem_d;
   logic [BAW-1:0] wptr_q, wptr_d;
   logic [LW:0]    beat_q, beat_d;
   logic           wb_wen_q, wb_wen_d;
   logic [BAW-1:0] wb_waddr_q, wb_waddr_d;
   logic [DW-1:0]  wb_wdata_q, wb_wdata_d;
   logic [LW-1:0]  exp_w;
   logic [LW-1:0]  rem_next;
   logic [AW-1:0]  addr_next;

   // Largest power of two not above min(rem, 1<<MAX_BURST_LOG); rem is nonzero when used.
   function automatic logic [3:0] burst_log(input logic [LW-1:0] rem);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 0; i < LW; i++)
         if (rem[i] && i <= MAX_BURST_LOG) r = 4'(i);
      if ((rem >> MAX_BURST_LOG) != '0) r = 4'(MAX_BURST_LOG);
      return r;
   endfunction

   assign exp_w     = {{(LW-1){1'b0}}, 1'b1} << arburst_q;
   assign rem_next  = rem_q - exp_w;
   assign addr_next = araddr_q + AW'(exp_w);

   always_comb begin
      state_d    = state_q;
      araddr_d   = araddr_q;
      arburst_d  = arburst_q;
      rem_d      = rem_q;
      wptr_d     = wptr_q;
      beat_d     = beat_q;
      wb_wen_d   = 1'b0;
      wb_waddr_d = wb_waddr_q;
      wb_wdata_d = wb_wdata_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               araddr_d = req_addr;
               rem_d    = req_len;
               wptr_d   = req_buf_base;
               beat_d   = '0;
               if (req_len == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d   = S_ADDR;
                  arburst_d = burst_log(req_len);
               end
            end
         end
         S_ADDR: begin
            if (arready) state_d = S_DATA;
         end
         S_DATA: begin
            if (rvalid) begin
               if (beat_q < {1'b0, exp_w}) begin
                  wb_wen_d   = 1'b1;
                  wb_waddr_d = wptr_q;
                  wb_wdata_d = rdata;
                  wptr_d     = wptr_q + 1'b1;
               end
               // Saturate so a runaway slave cannot wrap the counter back into the write window.
               if (beat_q != '1) beat_d = beat_q + 1'b1;
               if (rlast) begin
                  beat_d   = '0;
                  rem_d    = rem_next;
                  araddr_d = addr_next;
                  if (rem_next == '0) begin
                     state_d = S_DONE;
                  end else begin
                     state_d   = S_ADDR;
                     arburst_d = burst_log(rem_next);
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         araddr_q   <= '0;
         arburst_q  <= '0;
         rem_q      <= '0;
         wptr_q     <= '0;
         beat_q     <= '0;
         wb_wen_q   <= 1'b0;
         wb_waddr_q <= '0;
         wb_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         araddr_q   <= araddr_d;
         arburst_q  <= arburst_d;
         rem_q      <= rem_d;
         wptr_q     <= wptr_d;
         beat_q     <= beat_d;
         wb_wen_q   <= wb_wen_d;
         wb_waddr_q <= wb_waddr_d;
         wb_wdata_q <= wb_wdata_d;
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign arvalid   = (state_q == S_ADDR) && arready;
   assign araddr    = araddr_q;
   assign arburst   = arburst_q;
   assign wb_wen    = wb_wen_q;
   assign wb_waddr  = wb_waddr_q;
   assign wb_wdata  = wb_wdata_q;

endmodule
